// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and elaboration helpers for the UART baud generator.
package uart_pkg;
  localparam int CNT_W_DEF  = 13;
  localparam int FRAC_W_DEF = 3;
  localparam int OVS_DEF    = 16;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic bit ovs_ok(input int v);
    return v >= 4 && v <= 16 && (v & (v - 1)) == 0;
  endfunction
  function automatic bit frac_ok(input int v);
    return v >= 1 && v <= 8;
  endfunction
endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// uart_baud_gen_frac_if: control in, tick/pulse out between register file, UART FSMs and generator.
interface uart_baud_gen_frac_if #(parameter int CNT_W = 13, parameter int FRAC_W = 3);
  logic              enable;
  logic [CNT_W-1:0]  baud_val;
  logic [FRAC_W-1:0] baud_frac;
  logic              rx_restart;
  logic              baud_tick;
  logic              xmit_pulse;
  logic              rx_sample;
  modport master (output enable, baud_val, baud_frac, rx_restart, input baud_tick, xmit_pulse, rx_sample);
  modport slave  (input enable, baud_val, baud_frac, rx_restart, output baud_tick, xmit_pulse, rx_sample);
endinterface

// File: rtl/uart_frac_tick.sv
// uart_frac_tick: integer reload divider stretched by one cycle on fractional accumulator carry.
module uart_frac_tick
  import uart_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [CNT_W-1:0]  i_baud_val,
  input  logic [FRAC_W-1:0] i_baud_frac,
  output logic              o_baud_tick
);
  logic [CNT_W-1:0]  r_baud_cntr;
  logic [FRAC_W-1:0] r_frac_acc;
  logic              r_stretch;
  logic              r_baud_tick;
  logic [FRAC_W:0]   w_sum;
  assign w_sum = {1'b0, r_frac_acc} + {1'b0, i_baud_frac};
  // a carry out of the accumulator holds the counter at zero for one extra cycle
  always_ff @(posedge clk) begin
    if (reset || !i_enable) begin
      r_baud_cntr <= '0;
      r_frac_acc  <= '0;
      r_stretch   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (r_baud_cntr != '0) begin
      r_baud_cntr <= r_baud_cntr - 1'b1;
      r_baud_tick <= 1'b0;
    end else if (!r_stretch) begin
      r_baud_cntr              <= i_baud_val;
      {r_stretch, r_frac_acc}  <= w_sum;
      r_baud_tick              <= 1'b1;
    end else begin
      r_stretch   <= 1'b0;
      r_baud_tick <= 1'b0;
    end
  end
  assign o_baud_tick = r_baud_tick;
endmodule

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: fractional baud tick plus transmit bit pulse and restartable mid-bit receive sample.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVS    = OVS_DEF
) (
  input logic                  clk,
  input logic                  reset,
  uart_baud_gen_frac_if.slave  baud_if
);
  localparam int OVS_W = clog2(OVS);
  localparam logic [OVS_W-1:0] LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] MID  = OVS_W'(OVS / 2 - 1);
  if (!ovs_ok(OVS)) begin : g_bad_ovs
    $error("OVS must be a power of two in 4..16");
  end
  if (!frac_ok(FRAC_W)) begin : g_bad_frac
    $error("FRAC_W must be in 1..8");
  end
  logic             w_baud_tick;
  logic [OVS_W-1:0] r_xmit_cntr;
  logic [OVS_W-1:0] r_rx_phase;
  logic             r_rx_armed;
  uart_frac_tick #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) u_tick (
    .clk         (clk),
    .reset       (reset),
    .i_enable    (baud_if.enable),
    .i_baud_val  (baud_if.baud_val),
    .i_baud_frac (baud_if.baud_frac),
    .o_baud_tick (w_baud_tick)
  );
  // a restart coinciding with a tick swallows that tick so the phase starts from zero
  always_ff @(posedge clk) begin
    if (reset || !baud_if.enable) begin
      r_xmit_cntr <= '0;
      r_rx_phase  <= '0;
      r_rx_armed  <= 1'b0;
    end else begin
      if (w_baud_tick) r_xmit_cntr <= r_xmit_cntr + 1'b1;
      if (baud_if.rx_restart) begin
        r_rx_phase <= '0;
        r_rx_armed <= 1'b1;
      end else if (w_baud_tick) begin
        r_rx_phase <= r_rx_phase + 1'b1;
      end
    end
  end
  always_comb begin
    baud_if.baud_tick  = w_baud_tick;
    baud_if.xmit_pulse = w_baud_tick && r_xmit_cntr == LAST;
    baud_if.rx_sample  = w_baud_tick && r_rx_armed && !baud_if.rx_restart && r_rx_phase == MID;
  end
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: scoreboard of per-tick period and pulse expectations for narrow and wide-fraction generators.
module tb_uart_baud_gen_frac;
  typedef struct packed {logic [7:0] per; logic xp; logic rs;} exp_t;
  logic clk = 1'b0;
  logic reset;
  logic sel = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ntick = 0;
  int   rref = -1;
  int   last_cyc = 0;
  int   first_cyc = 0;
  int   t = 0;
  exp_t sb[$];
  logic w_tick, w_xp, w_rs;
  uart_baud_gen_frac_if #(.CNT_W(13), .FRAC_W(3)) ifn ();
  uart_baud_gen_frac_if #(.CNT_W(13), .FRAC_W(8)) ifw ();
  uart_baud_gen_frac #(.CNT_W(13), .FRAC_W(3), .OVS(16)) dut (.clk(clk), .reset(reset), .baud_if(ifn));
  uart_baud_gen_frac #(.CNT_W(13), .FRAC_W(8), .OVS(16)) dut_w (.clk(clk), .reset(reset), .baud_if(ifw));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    w_tick = sel ? ifw.baud_tick  : ifn.baud_tick;
    w_xp   = sel ? ifw.xmit_pulse : ifn.xmit_pulse;
    w_rs   = sel ? ifw.rx_sample  : ifn.rx_sample;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // period of tick j is bv+1 plus the number of 1/2^fw units crossed since tick j-1
  task automatic push(input int n, input int bv, input int bf, input int fw);
    exp_t e;
    int   base;
    base = ntick + sb.size();
    for (int i = 0; i < n; i++) begin
      int j;
      int m;
      j = base + i;
      m = j - rref;
      e.per = 8'((j == 0) ? 1 : bv + 1 + ((j * bf) >> fw) - (((j - 1) * bf) >> fw));
      e.xp  = (j % 16 == 15);
      e.rs  = (rref >= 0 && m > 0 && m % 16 == 8);
      sb.push_back(e);
    end
  endtask
  task automatic collect(input int n, input int prev, input string tag);
    int   got = 0;
    int   budget = 0;
    int   stray = 0;
    exp_t e;
    while (got < n && budget < 4000) begin
      @(negedge clk);
      budget++;
      if (w_tick) begin
        e = sb.pop_front();
        chk($sformatf("%s_tick%0d", tag, ntick), {22'd0, 8'(cyc - prev), w_xp, w_rs}, {22'd0, e.per, e.xp, e.rs});
        if (got == 0) first_cyc = cyc;
        prev = cyc;
        last_cyc = cyc;
        got++;
        ntick++;
      end else if (w_xp || w_rs) begin
        stray++;
      end
    end
    chk({tag, "_count"}, got, n);
    chk({tag, "_stray"}, stray, 0);
    sb.delete();
  endtask
  task automatic wait_tick(input string tag);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!w_tick && b < 100);
    chk(tag, {31'd0, w_tick}, 1);
    last_cyc = cyc;
    ntick++;
  endtask
  initial begin
    reset = 1'b1;
    ifn.enable = 1'b1; ifn.baud_val = 13'd3;  ifn.baud_frac = 3'd0;   ifn.rx_restart = 1'b0;
    ifw.enable = 1'b0; ifw.baud_val = 13'd10; ifw.baud_frac = 8'd128; ifw.rx_restart = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tick", {31'd0, ifn.baud_tick}, 0);
    chk("reset_xmit", {31'd0, ifn.xmit_pulse}, 0);
    chk("reset_rx", {31'd0, ifn.rx_sample}, 0);
    reset = 1'b0;
    ntick = 0; rref = -1; t = cyc;
    push(33, 3, 0, 3);
    collect(33, t, "int");
    repeat (3) @(negedge clk);
    ifn.enable = 1'b0;
    @(negedge clk);
    chk("disable_tick", {31'd0, ifn.baud_tick}, 0);
    chk("disable_xmit", {31'd0, ifn.xmit_pulse}, 0);
    for (int bf = 0; bf < 8; bf++) begin
      ifn.baud_frac = 3'(bf);
      ifn.enable = 1'b1;
      ntick = 0; rref = -1; t = cyc;
      push(257, 3, bf, 3);
      collect(257, t, $sformatf("frac%0d", bf));
      chk($sformatf("frac%0d_total", bf), last_cyc - first_cyc, 256 * 4 + 32 * bf);
      @(negedge clk);
      ifn.enable = 1'b0;
      @(negedge clk);
    end
    ifn.baud_frac = 3'd0;
    ifn.enable = 1'b1;
    ntick = 0; rref = -1; t = cyc;
    push(5, 3, 0, 3);
    collect(5, t, "pre_rx");
    wait_tick("rx_restart1_tick");
    ifn.rx_restart = 1'b1;
    #1 chk("rx_restart1_sample", {31'd0, ifn.rx_sample}, 0);
    rref = ntick - 1; t = last_cyc;
    @(posedge clk); #1 ifn.rx_restart = 1'b0;
    push(39, 3, 0, 3);
    collect(39, t, "rx1");
    wait_tick("rx_restart2_tick");
    ifn.rx_restart = 1'b1;
    #1 chk("rx_restart2_sample", {31'd0, ifn.rx_sample}, 0);
    rref = ntick - 1; t = last_cyc;
    @(posedge clk); #1 ifn.rx_restart = 1'b0;
    push(24, 3, 0, 3);
    collect(24, t, "rx2");
    wait_tick("bv_tick");
    t = last_cyc;
    @(negedge clk);
    ifn.baud_val = 13'd6;
    push(1, 3, 0, 3);
    push(2, 6, 0, 3);
    collect(3, t, "bv_change");
    @(negedge clk);
    ifn.enable = 1'b0;
    ifw.enable = 1'b1;
    sel = 1'b1;
    ntick = 0; rref = -1; t = cyc;
    push(257, 10, 128, 8);
    collect(257, t, "wide");
    chk("wide_total", last_cyc - first_cyc, 256 * 11 + 128);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
